// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
package clk_div_pkg;

  // Output mode; DIV_RSVD decodes as toggle.
  typedef enum logic [1:0] {
    DIV_TOGGLE = 2'd0,
    DIV_PULSE  = 2'd1,
    DIV_DUTY   = 2'd2,
    DIV_RSVD   = 2'd3
  } div_mode_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/clk_div_counter.sv
// Period counter for clk_div_prog: cnt register, wrap detect, enable and
// shadow-setting reload.
// Ports:
//   clk, reset          source clock, synchronous active-high reset
//   en                  count enable
//   mode/div_val/duty_val  requested settings (sampled on reset and wrap)
//   cnt                 registered counter value, 0..act_div
//   wrap_c              this edge completes a period
//   cnt_next_c          value cnt takes this edge
//   mode_next_c         mode governing the output on this edge
//   duty_next_c         duty threshold governing the output on this edge
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] duty_val,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap_c,
  output logic [WIDTH-1:0] cnt_next_c,
  output logic [1:0]       mode_next_c,
  output logic [WIDTH-1:0] duty_next_c
);

  div_mode_t        act_mode;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] act_duty;

  // Wrap is judged against the settings of the period being completed;
  // the output rule on a wrap edge already uses the incoming settings.
  always_comb begin
    wrap_c      = en && (cnt == act_div);
    cnt_next_c  = cnt;
    mode_next_c = act_mode;
    duty_next_c = act_duty;
    if (wrap_c) begin
      cnt_next_c  = '0;
      mode_next_c = mode;
      duty_next_c = duty_val;
    end else if (en) begin
      cnt_next_c  = cnt + WIDTH'(1);
    end
  end

  // Counter and shadow registers; shadows only reload at a period boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      act_mode <= div_mode_t'(mode);
      act_div  <= div_val;
      act_duty <= duty_val;
    end else begin
      cnt <= cnt_next_c;
      if (wrap_c) begin
        act_mode <= div_mode_t'(mode);
        act_div  <= div_val;
        act_duty <= duty_val;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with toggle, pulse and duty modes.
// Settings change only at the period boundary, so clk_out never glitches.
// Ports:
//   clk, reset   source clock, synchronous active-high reset
//   en           count enable; low freezes cnt and clk_out
//   mode         0=toggle, 1=pulse, 2=duty, 3=toggle
//   div_val      terminal count N (period N+1 counts)
//   duty_val     high cycles per period in duty mode
//   clk_out      divided output (registered)
//   tick         one-cycle strobe per completed period (registered)
//   cnt          current counter value (registered)
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] duty_val,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cnt
);

  logic             wrap_c;
  logic [WIDTH-1:0] cnt_next_c;
  logic [1:0]       mode_next_c;
  logic [WIDTH-1:0] duty_next_c;
  logic             clk_out_next_c;

  clk_div_counter #(.WIDTH(WIDTH)) u_counter (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .div_val     (div_val),
    .duty_val    (duty_val),
    .cnt         (cnt),
    .wrap_c      (wrap_c),
    .cnt_next_c  (cnt_next_c),
    .mode_next_c (mode_next_c),
    .duty_next_c (duty_next_c)
  );

  // Mode decode for the next clk_out value (only used while en=1).
  always_comb begin
    clk_out_next_c = clk_out;
    case (div_mode_t'(mode_next_c))
      DIV_PULSE: clk_out_next_c = wrap_c;
      DIV_DUTY:  clk_out_next_c = (cnt_next_c < duty_next_c);
      default:   clk_out_next_c = wrap_c ? ~clk_out : clk_out;
    endcase
  end

  // Output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      clk_out <= clk_out_next_c;
      tick    <= wrap_c;
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule
